// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: state encodings, port ids and helpers shared by the data-memory arbiter.
// The stats counter width lives here so the optional DMEM_ARB_STATS_EN build stays consistent.
package dmem_arb_pkg;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t IDLE   = 1'b0;
  localparam arb_state_t LOCK_B = 1'b1;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int STATS_W = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] val);
    logic [STATS_W-1:0] res;
    if (val == {STATS_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + {{(STATS_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: combinational two-way round-robin picker; bit 0 is port A, bit 1 is port B.
// force_b masks port A out entirely while B owns the memory.
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       force_b,
  output logic [1:0] gnt
);

  // One-hot pick; on contention the port that was not granted last wins.
  always_comb begin
    gnt = 2'b00;
    if (force_b) begin
      gnt = {req[1], 1'b0};
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_gnt == PORT_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the MEM stage (A) and the debug/loader
// port (B) with round-robin arbitration and a bounded B lock. DMEM_ARB_STATS_EN adds counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8,
  parameter int CNT_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_stall,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] o_conflict_cnt,
  output logic [STATS_W-1:0] o_a_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  logic             last_gnt_r;
  logic             last_gnt_nxt_s;
  logic [CNT_W-1:0] lock_cnt_r;
  logic [CNT_W-1:0] lock_cnt_nxt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             relock_blk_r;
  logic             relock_nxt_s;
  logic [1:0]       pick_s;
  logic             a_gnt_s;
  logic             b_gnt_s;
  logic             a_load_s;
  logic             b_load_s;

  arb_rr2 u_rr (
    .req      ({b_req, a_req}),
    .last_gnt (last_gnt_r),
    .force_b  (state_r == LOCK_B),
    .gnt      (pick_s)
  );

  // Grants (and therefore memory writes) are held off while reset is asserted.
  assign a_gnt_s  = pick_s[0] & i_rst_n;
  assign b_gnt_s  = pick_s[1] & i_rst_n;
  assign a_load_s = a_gnt_s & ~a_we;
  assign b_load_s = b_gnt_s & ~b_we;

  assign a_gnt   = a_gnt_s;
  assign b_gnt   = b_gnt_s;
  assign a_stall = a_req & ~a_gnt_s;

  assign m_we    = (a_gnt_s & a_we) | (b_gnt_s & b_we);
  assign m_addr  = b_gnt_s ? b_addr  : a_addr;
  assign m_wdata = b_gnt_s ? b_wdata : a_wdata;

  assign cnt_inc_s = (lock_cnt_r >= MAX_CNT) ? MAX_CNT : (lock_cnt_r + ONE_CNT);

  // Lock FSM next state, beat counter and re-lock blocking flag.
  always_comb begin
    state_nxt_s    = state_r;
    lock_cnt_nxt_s = lock_cnt_r;
    relock_nxt_s   = relock_blk_r;
    if (a_gnt_s) begin
      last_gnt_nxt_s = PORT_A;
    end else if (b_gnt_s) begin
      last_gnt_nxt_s = PORT_B;
    end else begin
      last_gnt_nxt_s = last_gnt_r;
    end
    case (state_r)
      IDLE: begin
        if (!b_lock) begin
          relock_nxt_s = 1'b0;
        end else if (b_gnt_s && !relock_blk_r) begin
          // The entry beat already counts; a one-beat limit never enters the lock.
          if (MAX_CNT > ONE_CNT) begin
            state_nxt_s    = LOCK_B;
            lock_cnt_nxt_s = ONE_CNT;
          end else begin
            relock_nxt_s = 1'b1;
          end
        end else begin
          relock_nxt_s = relock_blk_r;
        end
      end
      LOCK_B: begin
        if (b_gnt_s) begin
          lock_cnt_nxt_s = cnt_inc_s;
        end else begin
          lock_cnt_nxt_s = lock_cnt_r;
        end
        if (!b_lock || !b_req || (b_gnt_s && (cnt_inc_s == MAX_CNT))) begin
          state_nxt_s    = IDLE;
          lock_cnt_nxt_s = ZERO_CNT;
          relock_nxt_s   = b_lock;
          last_gnt_nxt_s = PORT_B;
        end else begin
          state_nxt_s = LOCK_B;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        lock_cnt_nxt_s = ZERO_CNT;
        relock_nxt_s   = 1'b0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      last_gnt_r   <= PORT_B;
      lock_cnt_r   <= ZERO_CNT;
      relock_blk_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      last_gnt_r   <= last_gnt_nxt_s;
      lock_cnt_r   <= lock_cnt_nxt_s;
      relock_blk_r <= relock_nxt_s;
    end
  end

  // Per-port read return: one-cycle valid pulse, data held until the next load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= {DATA_W{1'b0}};
      b_rdata  <= {DATA_W{1'b0}};
    end else begin
      a_rvalid <= a_load_s;
      b_rvalid <= b_load_s;
      if (a_load_s) begin
        a_rdata <= m_rdata;
      end
      if (b_load_s) begin
        b_rdata <= m_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [STATS_W-1:0] conflict_cnt_r;
  logic [STATS_W-1:0] a_stall_cnt_r;

  // Saturating contention and stall statistics.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      conflict_cnt_r <= {STATS_W{1'b0}};
      a_stall_cnt_r  <= {STATS_W{1'b0}};
    end else begin
      if (a_req & b_req) begin
        conflict_cnt_r <= sat_inc(conflict_cnt_r);
      end
      if (a_stall) begin
        a_stall_cnt_r <= sat_inc(a_stall_cnt_r);
      end
    end
  end

  assign o_conflict_cnt = conflict_cnt_r;
  assign o_a_stall_cnt  = a_stall_cnt_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table vectors, hand-written lock/reset sequences and random traffic,
// all checked against a transaction-level model of the arbitration rules and memory contents.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int ML = 8;

  typedef struct {
    logic        ar;
    logic        aw;
    logic [31:0] aa;
    logic [31:0] ad;
    logic        br;
    logic        bw;
    logic        bl;
    logic [31:0] ba;
    logic [31:0] bd;
    logic        eag;
    logic        ebg;
    logic        emwe;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req, a_we, a_gnt, a_stall, a_rvalid;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt, a_stall_cnt;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(ML), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .o_conflict_cnt(conflict_cnt), .o_a_stall_cnt(a_stall_cnt)
`endif
  );

  // Memory: async read, write on posedge; a loader path fills it during reset.
  logic [31:0] mem [16];
  logic        ld_en;
  logic [3:0]  ld_idx;
  logic [31:0] ld_val;
  assign m_rdata = mem[m_addr[5:2]];
  always @(posedge clk) begin
    if (m_we) mem[m_addr[5:2]] <= m_wdata;
    else if (ld_en) mem[ld_idx] <= ld_val;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ref_mem [16];
  bit          m_locked, m_relock, m_last_b;
  int          m_beats;
  bit          e_arv, e_brv;
  logic [31:0] e_ard, e_brd;
  int          e_conf, e_stall;
  bit          samp_ag, samp_bg;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ar, aw, input logic [31:0] aa, ad,
                              input logic br, bw, bl, input logic [31:0] ba, bd,
                              input logic eag, ebg, emwe);
    vec_t v;
    v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br; v.bw = bw; v.bl = bl; v.ba = ba; v.bd = bd;
    v.eag = eag; v.ebg = ebg; v.emwe = emwe;
    return v;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0; m_relock = 1'b0; m_last_b = 1'b1; m_beats = 0;
    e_arv = 1'b0; e_brv = 1'b0; e_ard = 32'h0; e_brd = 32'h0;
    e_conf = 0; e_stall = 0;
  endtask

  task automatic drive_idle();
    a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
  endtask

  // One clock cycle: drive, check combinational and registered outputs, advance the model.
  task automatic step(input vec_t v);
    bit ga, gb;
    @(negedge clk);
    a_req = v.ar; a_we = v.aw; a_addr = v.aa; a_wdata = v.ad;
    b_req = v.br; b_we = v.bw; b_lock = v.bl; b_addr = v.ba; b_wdata = v.bd;
    #1;
    if (m_locked) begin
      ga = 1'b0; gb = v.br;
    end else if (v.ar && v.br) begin
      ga = m_last_b; gb = !m_last_b;
    end else begin
      ga = v.ar; gb = v.br;
    end
    chk1("a_gnt", a_gnt, ga);
    chk1("b_gnt", b_gnt, gb);
    chk1("a_stall", a_stall, v.ar && !ga);
    chk1("m_we", m_we, (ga && v.aw) || (gb && v.bw));
    chk32("m_addr", m_addr, gb ? v.ba : v.aa);
    chk32("m_wdata", m_wdata, gb ? v.bd : v.ad);
    chk1("a_rvalid", a_rvalid, e_arv);
    chk1("b_rvalid", b_rvalid, e_brv);
    chk32("a_rdata", a_rdata, e_ard);
    chk32("b_rdata", b_rdata, e_brd);
`ifdef DMEM_ARB_STATS_EN
    chk32("conflict_cnt", 32'(conflict_cnt), 32'(e_conf));
    chk32("a_stall_cnt", 32'(a_stall_cnt), 32'(e_stall));
`endif
    samp_ag = a_gnt; samp_bg = b_gnt;
    e_arv = ga && !v.aw;
    e_brv = gb && !v.bw;
    if (e_arv) e_ard = ref_mem[v.aa[5:2]];
    if (e_brv) e_brd = ref_mem[v.ba[5:2]];
    if (ga && v.aw) ref_mem[v.aa[5:2]] = v.ad;
    if (gb && v.bw) ref_mem[v.ba[5:2]] = v.bd;
    if (v.ar && v.br && e_conf < 65535) e_conf++;
    if (v.ar && !ga && e_stall < 65535) e_stall++;
    if (ga) m_last_b = 1'b0;
    if (gb) m_last_b = 1'b1;
    if (m_locked) begin
      if (gb && m_beats < ML) m_beats++;
      if (!v.bl || !v.br || (gb && m_beats == ML)) begin
        m_locked = 1'b0; m_last_b = 1'b1; m_relock = v.bl;
      end
    end else if (!v.bl) begin
      m_relock = 1'b0;
    end else if (gb && !m_relock) begin
      m_locked = 1'b1; m_beats = 1;
    end
  endtask

  initial begin
    vec_t tbl [9];
    vec_t rv;
    bit   lockv;
    int   run;
    bit   ended;

    drive_idle();
    ld_en = 1'b0; ld_idx = 4'h0; ld_val = 32'h0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_idx = 4'(i);
      ld_val = (i == 1) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i));
      ref_mem[i] = ld_val;
    end
    @(negedge clk);
    ld_en = 1'b0;
    a_req = 1'b1; b_req = 1'b1; b_we = 1'b1;
    #1;
    chk1("rst_a_gnt", a_gnt, 1'b0);
    chk1("rst_b_gnt", b_gnt, 1'b0);
    chk1("rst_m_we", m_we, 1'b0);
    chk1("rst_a_rvalid", a_rvalid, 1'b0);
    chk1("rst_b_rvalid", b_rvalid, 1'b0);
    chk32("rst_a_rdata", a_rdata, 32'h0);
    chk32("rst_b_rdata", b_rdata, 32'h0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Table: single A load, then contention alternating A/B with A stores and B loads.
    tbl[0] = mk(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tbl[1] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 8; i++)
      tbl[i] = mk(1'b1, 1'b1, 32'h8, 32'h10 + 32'(i), 1'b1, 1'b0, 1'b0, 32'h4, 32'h0,
                  1'(i % 2), 1'((i + 1) % 2), 1'(i % 2));
    tbl[8] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(tbl[i]);
      chk1("tbl_a_gnt", samp_ag, tbl[i].eag);
      chk1("tbl_b_gnt", samp_bg, tbl[i].ebg);
      chk1("tbl_m_we", m_we, tbl[i].emwe);
      if (i == 1) begin
        chk1("load_rvalid", a_rvalid, 1'b1);
        chk32("load_rdata", a_rdata, 32'hDEADBEEF);
        chk1("load_b_rvalid", b_rvalid, 1'b0);
      end
    end

    // Locked burst of four B stores while A keeps requesting.
    for (int i = 0; i < 4; i++) begin
      step(mk(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 1'b1, 32'(i * 4), 32'(i + 1),
              1'b0, 1'b0, 1'b0));
      chk1("burst_b_gnt", samp_bg, 1'b1);
      chk1("burst_a_stall", a_stall, 1'b1);
    end
    step(mk(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    chk1("drop_no_b", samp_bg, 1'b0);
    step(mk(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    chk1("a_after_drop", samp_ag, 1'b1);
    step(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) chk32("burst_mem", mem[i], 32'(i + 1));

    // B holds lock for 12 cycles: forced release after ML beats, no immediate relock.
    run = 0; ended = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(mk(1'b1, 1'b0, 32'h24, 32'h0, 1'b1, 1'b0, 1'b1, 32'h28, 32'h0, 1'b0, 1'b0, 1'b0));
      if (i == 8) chk1("a_after_release", samp_ag, 1'b1);
      if (i == 9) chk1("b_unlocked_gnt", samp_bg, 1'b1);
      if (i == 10) chk1("no_relock", samp_ag, 1'b1);
      if (samp_bg && !ended) run++;
      else ended = 1'b1;
    end
    chk32("lock_run_len", 32'(run), 32'(ML));
    step(mk(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    step(mk(1'b1, 1'b0, 32'h24, 32'h0, 1'b1, 1'b0, 1'b1, 32'h28, 32'h0, 1'b0, 1'b0, 1'b0));
    step(mk(1'b1, 1'b0, 32'h24, 32'h0, 1'b1, 1'b0, 1'b1, 32'h28, 32'h0, 1'b0, 1'b0, 1'b0));
    chk1("relock_after_toggle", samp_bg, 1'b1);
    step(mk(1'b1, 1'b0, 32'h24, 32'h0, 1'b1, 1'b0, 1'b0, 32'h28, 32'h0, 1'b0, 1'b0, 1'b0));

    // Reset asserted during a locked B store.
    step(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b1; b_lock = 1'b1;
    b_addr = 32'h34; b_wdata = 32'hBAD0BAD0;
    #1;
    chk1("pre_rst_m_we", m_we, 1'b1);
    chk1("pre_rst_b_rvalid", b_rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("midrst_m_we", m_we, 1'b0);
    chk1("midrst_a_gnt", a_gnt, 1'b0);
    chk1("midrst_b_gnt", b_gnt, 1'b0);
    chk1("midrst_b_rvalid", b_rvalid, 1'b0);
    chk1("midrst_a_rvalid", a_rvalid, 1'b0);
    chk32("midrst_a_rdata", a_rdata, 32'h0);
    chk32("midrst_b_rdata", b_rdata, 32'h0);
    @(posedge clk);
    #1;
    chk32("midrst_mem_kept", mem[13], ref_mem[13]);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    model_reset();

    // Five contended cycles straight after reset; A must win first (IDLE, last=B).
    for (int i = 0; i < 5; i++) begin
      step(mk(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 1'b0, 1'b0, 1'b0));
      if (i == 0) chk1("idle_after_rst", samp_ag, 1'b1);
    end
    step(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
`ifdef DMEM_ARB_STATS_EN
    chk32("stats_conflict5", 32'(conflict_cnt), 32'd5);
    chk32("stats_stall2", 32'(a_stall_cnt), 32'd2);
`endif

    // Random traffic against the model.
    lockv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) lockv = ~lockv;
      rv = mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom,
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), lockv, $urandom,
              $urandom, 1'b0, 1'b0, 1'b0);
      step(rv);
    end
    step(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 16; i++) chk32("final_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (async read, sync write on posedge) between two requesters.
- Port A is the pipeline MEM stage; port B is the debug/loader port.
- Round-robin arbitration, with an optional bounded lock so port B can issue back-to-back beats.
- Read data is registered per port with fixed 1-cycle latency; port A gets a stall indication for hazard logic.

Parameters:
- ADDR_W, 32, address width of both ports and the memory side.
- DATA_W, 32, data width.
- MAX_LOCK, 8, maximum consecutive granted B beats while locked (1..255).
- CNT_W, 8, width of the lock beat counter; must hold MAX_LOCK.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- a_req  in  1  port A access request
- a_we  in  1  port A write enable (1=store, 0=load)
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A store data
- a_gnt  out  1  port A granted this cycle (combinational)
- a_stall  out  1  a_req & ~a_gnt
- a_rvalid  out  1  port A load data valid (registered)
- a_rdata  out  DATA_W  port A load data (registered)
- b_req  in  1  port B access request
- b_we  in  1  port B write enable
- b_lock  in  1  port B requests exclusive burst
- b_addr  in  ADDR_W  port B address
- b_wdata  in  DATA_W  port B store data
- b_gnt  out  1  port B granted this cycle (combinational)
- b_rvalid  out  1  port B load data valid (registered)
- b_rdata  out  DATA_W  port B load data (registered)
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory async read data

Behaviour:
- Clock and reset are fixed: single clock i_clk; i_rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, last_gnt=B (so A wins the first contention), lock_cnt=0.
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - m_we is gated to 0 combinationally while i_rst_n=0, so no memory write occurs during reset.
  - a_gnt=b_gnt=0 while i_rst_n=0.
- Grants are combinational and at most one per cycle. A granted access completes in its grant cycle: the write commits at that posedge, the read samples m_rdata at that posedge.
- Memory mux:
  - Granted port drives m_addr/m_wdata; m_we = granted port's we.
  - No grant: m_we=0, m_addr=a_addr, m_wdata=a_wdata.
- Read return:
  - On a granted load (gnt & ~we), the port's rdata<=m_rdata and rvalid<=1 at the posedge.
  - rvalid is a 1-cycle pulse; rdata holds until the next granted load on that port.
  - Stores never raise rvalid.
- IDLE arbitration:
  - Only one req: that port is granted.
  - Both req: grant the port != last_gnt.
  - last_gnt updates on every grant.
- Transition IDLE->LOCK_B: B granted with b_lock=1. lock_cnt<=1.
- LOCK_B behaviour:
  - A is never granted; B is granted whenever b_req=1.
  - lock_cnt increments per granted B beat and saturates at MAX_LOCK.
- LOCK_B->IDLE (registered) on any of:
  - b_lock sampled 0;
  - a granted beat brings lock_cnt to MAX_LOCK;
  - b_req=0 for 1 cycle.
  - On exit, last_gnt<=B so A wins the next contention.
  - B cannot relock until it has dropped b_lock for at least one cycle; a pending re-lock flag blocks entry.
- Starvation bound: A waits at most MAX_LOCK+1 cycles behind B.
- Reset asserted mid-burst: state returns to IDLE immediately, and in-flight rvalid pulses are cleared.
- Addresses pass through unmodified; there is no alignment check.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN
- When defined, adds output o_conflict_cnt[15:0]: saturating count of cycles with a_req&b_req, cleared on reset.
- Also adds output o_a_stall_cnt[15:0]: saturating count of a_stall cycles.
- When undefined, neither port nor counter exists; arbitration behaviour is identical in both builds.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, LOCK_B};
  - port-id constants PORT_A=0, PORT_B=1;
  - the counter width constant for the stats counters.
- Natural sub-module: arb_rr2, a 2-way round-robin picker.
  - Inputs: req[1:0], last_gnt, force_b.
  - Output: one-hot gnt[1:0].
  - Purely combinational; last_gnt is held in the parent.

Test Plan:
- Single A load to addr 0x4, mem[1]=0xDEADBEEF, b_req=0 -> a_gnt same cycle; next cycle a_rvalid=1, a_rdata=0xDEADBEEF; b_rvalid stays 0.
- A and B both request continuously, no lock, after reset -> grants alternate A,B,A,B; a_stall high on B cycles; m_we follows the granted port's we.
- B locked burst of 4 writes (addr 0..0xC, data 1..4) while A requests -> b_gnt 4 consecutive cycles, a_stall=1 throughout; after b_lock drops, A granted first; mem holds 1..4.
- B holds lock and req for 12 cycles with MAX_LOCK=8 -> exactly 8 B grants, forced release, A granted on the next cycle; B cannot relock until b_lock toggles low.
- Assert i_rst_n low mid-burst during a B store -> m_we=0 immediately, the target mem word is unchanged, all outputs are zero, and state is IDLE on release.
- With DMEM_ARB_STATS_EN, 5 cycles of simultaneous requests -> o_conflict_cnt=5; o_a_stall_cnt equals the number of cycles where a_req was high and a_gnt low.
